// File: rtl/srio_pkg.sv
// SRIO Gen2 shared definitions: NWRITE FTYPE/TTYPE codes, the HELLO
// header layout and a helper that assembles one header beat.
// Shared by the NWRITE packetizer and the upcoming NREAD/response blocks.
package srio_pkg;

  localparam logic [3:0] FTYPE_NWRITE = 4'd5;
  localparam logic [3:0] TTYPE_NWRITE = 4'd4;

  // HELLO header beat, MSB first. Reserved fields must be driven 0.
  typedef struct packed {
    logic [7:0]  tid;
    logic [3:0]  ftype;
    logic [3:0]  ttype;
    logic        rsvd47;
    logic [1:0]  prio;
    logic        crf;
    logic [7:0]  size;   // payload bytes - 1
    logic [1:0]  rsvd35;
    logic [33:0] addr;
  } hello_hdr_t;

  function automatic hello_hdr_t build_hello(input logic [7:0]  tid,
                                             input logic [3:0]  ftype,
                                             input logic [3:0]  ttype,
                                             input logic [1:0]  prio,
                                             input logic        crf,
                                             input logic [7:0]  size,
                                             input logic [33:0] addr);
    hello_hdr_t h;
    h.tid    = tid;
    h.ftype  = ftype;
    h.ttype  = ttype;
    h.rsvd47 = 1'b0;
    h.prio   = prio;
    h.crf    = crf;
    h.size   = size;
    h.rsvd35 = 2'b00;
    h.addr   = addr;
    return h;
  endfunction

endpackage

// File: rtl/nwrite_packetizer.sv
// nwrite_packetizer: requests a buffered burst from input_reader, consumes
// the replayed AXI-stream and cuts it into SRIO NWRITE packets of at most
// MAX_PKT_BEATS payload beats, each led by one HELLO header beat on ireq.
// Ports:
//   clk/reset        log_clk, synchronous active-high reset
//   start_i, len_i, addr_i, dest_id_i, src_id_i   burst request (len in beats)
//   busy_o, done_o, len_err_o                     status
//   fetch_data_out                                one-cycle replay request
//   s_t*                                          payload stream in
//   ireq_t*                                       packets out to the SRIO core
module nwrite_packetizer #(
  parameter int DATA_WIDTH        = 64,
  parameter int DATA_LENGTH_WIDTH = 20,
  parameter int MAX_PKT_BEATS     = 32,
  parameter int ADDR_WIDTH        = 34
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [DATA_LENGTH_WIDTH-1:0] len_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [15:0]                  dest_id_i,
  input  logic [15:0]                  src_id_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         len_err_o,
  output logic                         fetch_data_out,
  input  logic [DATA_WIDTH-1:0]        s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [DATA_WIDTH/8-1:0]      s_tkeep,
  input  logic                         s_tlast,
  output logic [DATA_WIDTH-1:0]        ireq_tdata,
  output logic                         ireq_tvalid,
  input  logic                         ireq_tready,
  output logic [DATA_WIDTH/8-1:0]      ireq_tkeep,
  output logic                         ireq_tlast,
  output logic [31:0]                  ireq_tuser
);
  import srio_pkg::*;

  localparam int PKT_W = $clog2(MAX_PKT_BEATS + 1);
  localparam int LW    = DATA_LENGTH_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HDR, S_DATA, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     len_rem;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]       ids_q;
  logic [7:0]        tid_q;
  logic [PKT_W-1:0]  beat_cnt, pkt_beats;
  hello_hdr_t        hdr_q;
  logic              len_err_q;

  // Payload handshake and packet-boundary bookkeeping
  logic                  hs, pkt_end, hdr_load;
  logic [LW-1:0]         rem_dec, hdr_rem;
  logic [ADDR_WIDTH-1:0] addr_adv, hdr_addr;
  logic [7:0]            hdr_tid;
  logic [PKT_W-1:0]      nxt_beats;
  logic [PKT_W+2:0]      size_full;

  assign hs        = (state == S_DATA) && s_tvalid && ireq_tready;
  assign pkt_end   = (beat_cnt == pkt_beats - PKT_W'(1));
  assign rem_dec   = len_rem - LW'(1);
  assign addr_adv  = addr_q + ADDR_WIDTH'({pkt_beats, 3'b000});

  // The next header is built one cycle ahead so it is ready on HDR entry:
  // from the latched request in FETCH, or from the post-packet values
  // on the closing beat of a non-final packet.
  assign hdr_load  = (state == S_FETCH) || (hs && pkt_end && (rem_dec != '0));
  assign hdr_rem   = (state == S_FETCH) ? len_rem : rem_dec;
  assign hdr_addr  = (state == S_FETCH) ? addr_q  : addr_adv;
  assign hdr_tid   = (state == S_FETCH) ? tid_q   : tid_q + 8'd1;
  assign nxt_beats = (hdr_rem >= LW'(MAX_PKT_BEATS)) ? PKT_W'(MAX_PKT_BEATS)
                                                      : hdr_rem[PKT_W-1:0];
  assign size_full = {nxt_beats, 3'b000} - (PKT_W+3)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_rem   <= '0;
      addr_q    <= '0;
      ids_q     <= '0;
      tid_q     <= '0;
      beat_cnt  <= '0;
      pkt_beats <= '0;
      hdr_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start_i && len_i != '0) begin
        len_rem <= len_i;
        addr_q  <= addr_i;
        ids_q   <= {src_id_i, dest_id_i};
      end
      if (hs) begin
        len_rem  <= rem_dec;
        beat_cnt <= pkt_end ? '0 : beat_cnt + PKT_W'(1);
        if (pkt_end) begin
          addr_q <= addr_adv;
          tid_q  <= tid_q + 8'd1;
        end
        // Early tlast, or a missing tlast on the final beat.
        if ((s_tlast && len_rem > LW'(1)) || (!s_tlast && len_rem == LW'(1)))
          len_err_q <= 1'b1;
      end
      if (hdr_load) begin
        pkt_beats <= nxt_beats;
        hdr_q     <= build_hello(hdr_tid, FTYPE_NWRITE, TTYPE_NWRITE, 2'b01,
                                 1'b0, size_full[7:0], hdr_addr[33:0]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = (len_i != '0) ? S_FETCH : S_DONE;
      S_FETCH: state_nxt = S_HDR;
      S_HDR:   if (ireq_tready) state_nxt = S_DATA;
      S_DATA:  if (hs && pkt_end) state_nxt = (rem_dec == '0) ? S_DONE : S_HDR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state != S_IDLE);
    done_o         = 1'b0;
    fetch_data_out = 1'b0;
    s_tready       = 1'b0;
    ireq_tvalid    = 1'b0;
    ireq_tdata     = '0;
    ireq_tkeep     = '0;
    ireq_tlast     = 1'b0;
    case (state)
      S_FETCH: fetch_data_out = 1'b1;
      S_HDR: begin
        ireq_tvalid = 1'b1;
        ireq_tdata  = hdr_q;
        ireq_tkeep  = '1;
      end
      // Zero-latency pass-through; backpressure goes straight upstream.
      S_DATA: begin
        ireq_tvalid = s_tvalid;
        s_tready    = ireq_tready;
        ireq_tdata  = s_tdata;
        ireq_tkeep  = s_tkeep;
        ireq_tlast  = pkt_end;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign ireq_tuser = ids_q;
  assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_nwrite_packetizer.sv
module tb_nwrite_packetizer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [19:0] len_i;
  logic [33:0] addr_i;
  logic [15:0] dest_id_i, src_id_i;
  logic        busy_o, done_o, len_err_o, fetch_data_out;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tkeep;
  logic [63:0] ireq_tdata;
  logic        ireq_tvalid, ireq_tready, ireq_tlast;
  logic [7:0]  ireq_tkeep;
  logic [31:0] ireq_tuser;

  always #5 clk = ~clk;

  nwrite_packetizer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i), .addr_i(addr_i),
    .dest_id_i(dest_id_i), .src_id_i(src_id_i), .busy_o(busy_o), .done_o(done_o),
    .len_err_o(len_err_o), .fetch_data_out(fetch_data_out),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .ireq_tdata(ireq_tdata), .ireq_tvalid(ireq_tvalid),
    .ireq_tready(ireq_tready), .ireq_tkeep(ireq_tkeep), .ireq_tlast(ireq_tlast),
    .ireq_tuser(ireq_tuser)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m_tid = 8'd0;   // bench's own transaction-id counter
  logic       m_err = 1'b0;   // bench's own sticky length-error flag

  typedef struct {
    int          len;
    logic [33:0] addr;
    logic [15:0] dst, src;
    bit          gaps;
    int          tlast_at;
    int          exp_pkts;
    logic [7:0]  exp_last_size;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pay(input int i, input int tag);
    return {16'hC0DE, 16'(tag), 32'(i)};
  endfunction

  function automatic logic [7:0] kp(input int i);
    return (i % 3 == 0) ? 8'h0F : ((i % 3 == 1) ? 8'hFF : 8'hF0);
  endfunction

  function automatic logic [127:0] all_outs();
    return {17'd0, busy_o, done_o, len_err_o, fetch_data_out, s_tready,
            ireq_tdata, ireq_tvalid, ireq_tkeep, ireq_tlast, ireq_tuser};
  endfunction

  task automatic idle_inputs();
    start_i = 0; len_i = '0; addr_i = '0; dest_id_i = '0; src_id_i = '0;
    s_tdata = '0; s_tvalid = 0; s_tkeep = '0; s_tlast = 0; ireq_tready = 0;
  endtask

  task automatic run_burst(input vec_t v, input int tag);
    logic [63:0] cd[$];
    logic [7:0]  ck[$];
    logic        cl[$];
    logic [63:0] ed[$];
    logic [7:0]  ek[$];
    logic        el[$];
    int idx = 0, fetches = 0, npk = 0, rem, pb, src_i = 0;
    bit done_seen = 0, s_pend = 0, stall = 0, nxt_hdr = 1;
    logic [63:0] prev_data = '0, last_hdr = '0;
    logic [33:0] a;

    @(negedge clk);
    start_i = 1; len_i = 20'(v.len); addr_i = v.addr; dest_id_i = v.dst; src_id_i = v.src;
    for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
      @(negedge clk);
      start_i = 0;
      if (!s_pend) s_tvalid = (idx < v.len) && (!v.gaps || $urandom_range(0, 3) != 0);
      s_tdata = pay(idx, tag); s_tkeep = kp(idx); s_tlast = (idx == v.tlast_at - 1);
      ireq_tready = !v.gaps || ($urandom_range(0, 2) != 0);
      #1;
      if (cyc == 0) begin
        chk("busy_after_start", busy_o, 1);
        chk("tuser_ids", ireq_tuser, {v.src, v.dst});
      end
      if (stall) begin
        chk("stall_valid_held", ireq_tvalid, 1);
        chk("stall_data_held", ireq_tdata, prev_data);
      end
      stall = ireq_tvalid && !ireq_tready;
      prev_data = ireq_tdata;
      if (fetch_data_out) fetches++;
      if (ireq_tvalid && ireq_tready) begin
        if (nxt_hdr) begin last_hdr = ireq_tdata; npk++; end
        nxt_hdr = ireq_tlast;
        cd.push_back(ireq_tdata); ck.push_back(ireq_tkeep); cl.push_back(ireq_tlast);
      end
      if (s_tvalid && s_tready) begin idx++; s_pend = 0; end
      else s_pend = s_tvalid;
      if (done_o) done_seen = 1;
    end
    s_tvalid = 0; s_tlast = 0; ireq_tready = 0;
    chk($sformatf("done_within_budget_len%0d", v.len), done_seen, 1);
    chk("fetch_pulses", fetches, 1);
    chk("payload_consumed", idx, v.len);
    chk("packet_count", npk, v.exp_pkts);
    chk("last_hdr_size", last_hdr[43:36], v.exp_last_size);

    // Expected ireq stream
    rem = v.len; a = v.addr;
    while (rem > 0) begin
      pb = (rem > 32) ? 32 : rem;
      ed.push_back({m_tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'(pb * 8 - 1), 2'b00, a});
      ek.push_back(8'hFF); el.push_back(1'b0);
      for (int j = 0; j < pb; j++) begin
        ed.push_back(pay(src_i, tag)); ek.push_back(kp(src_i)); el.push_back(j == pb - 1);
        src_i++;
      end
      a = a + 34'(pb * 8); m_tid = m_tid + 8'd1; rem = rem - pb;
    end
    chk("ireq_beat_count", cd.size(), ed.size());
    for (int i = 0; i < ed.size() && i < cd.size(); i++) begin
      chk($sformatf("beat%0d_data", i), cd[i], ed[i]);
      chk($sformatf("beat%0d_keep", i), ck[i], ek[i]);
      chk($sformatf("beat%0d_last", i), cl[i], el[i]);
    end

    @(negedge clk); #1;
    chk("done_one_cycle", done_o, 0);
    chk("busy_clear", busy_o, 0);
    m_err = m_err | v.exp_err;
    chk("len_err", len_err_o, m_err);
  endtask

  initial begin
    vec_t vt[6];
    vec_t post;
    int hs_cnt;

    vt[0] = '{4,    34'h1000,       16'h0011, 16'h0022, 0, 4,    1,   8'h1F, 0};
    vt[1] = '{268,  34'h2_0000_0000, 16'h1234, 16'h5678, 0, 268,  9,   8'h5F, 0};
    vt[2] = '{40,   34'h0_0040_0000, 16'hAAAA, 16'h5555, 1, 40,   2,   8'h3F, 0};
    vt[3] = '{33,   34'h3_FFFF_0000, 16'h0001, 16'h0002, 0, 33,   2,   8'h07, 0};
    vt[4] = '{8224, 34'h0_1000_0000, 16'h00F0, 16'h000F, 0, 8224, 257, 8'hFF, 0};
    vt[5] = '{12,   34'h8000,       16'hBEEF, 16'hCAFE, 0, 10,   1,   8'h5F, 1};

    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    @(negedge clk);
    reset = 0;

    // Zero-length start: straight to done, no fetch.
    start_i = 1; len_i = '0; addr_i = 34'h40;
    @(negedge clk);
    start_i = 0;
    #1;
    chk("len0_done", done_o, 1);
    chk("len0_no_fetch", fetch_data_out, 0);
    @(negedge clk); #1;
    chk("len0_done_clear", done_o, 0);
    chk("len0_idle", busy_o, 0);

    for (int t = 0; t < 6; t++) run_burst(vt[t], t + 1);

    // Reset in the middle of packet 2 of a 100-beat burst.
    @(negedge clk);
    start_i = 1; len_i = 20'd100; addr_i = 34'h9000; dest_id_i = 16'h7; src_id_i = 16'h9;
    hs_cnt = 0;
    for (int cyc = 0; cyc < 500 && hs_cnt < 39; cyc++) begin
      @(negedge clk);
      start_i = 0; s_tvalid = 1; s_tdata = pay(cyc, 99); s_tkeep = 8'hFF; ireq_tready = 1;
      #1;
      if (ireq_tvalid && ireq_tready) hs_cnt++;
    end
    chk("reset_seq_reached_pkt2", hs_cnt, 39);
    @(negedge clk);
    reset = 1;
    @(negedge clk); #1;
    chk("midburst_reset_outputs", all_outs(), '0);
    reset = 0;
    idle_inputs();
    m_tid = 8'd0; m_err = 1'b0;

    post = '{4, 34'h1000, 16'h0033, 16'h0044, 0, 4, 1, 8'h1F, 0};
    run_burst(post, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
